// File: rtl/dual_bus_pkg.sv
// dual_bus_pkg: shared types and helpers for the dual-channel redundant bus transmitter.
//   state_t        - transmitter FSM states
//   SYNC_WORD_DFLT - default frame sync word
//   csum_update    - running checksum step (acc XOR word), evaluated on a wide
//                    vector so any DATA_W up to CSUM_W can share it via casts
package dual_bus_pkg;

  localparam int unsigned CSUM_W = 64;

  localparam logic [7:0] SYNC_WORD_DFLT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYNC,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_GAP
  } state_t;

  function automatic logic [CSUM_W-1:0] csum_update(input logic [CSUM_W-1:0] acc,
                                                     input logic [CSUM_W-1:0] word);
    return acc ^ word;
  endfunction

endpackage

// File: rtl/dual_bus_buf.sv
// dual_bus_buf: single-frame payload buffer (MAX_LEN x DATA_W register file).
//   clk, rst     - clock, asynchronous active-high reset (clears pointers)
//   clr          - synchronous clear of write count and read pointer (frame done)
//   wr_en/wr_data- append a word at position 'count'
//   rd_en        - advance read pointer
//   rd_data_c    - word at the read pointer (combinational)
//   rd_last_c    - read pointer sits on the final stored word (combinational)
//   last_slot_c  - the next write fills the final slot (combinational)
//   count        - number of stored words
module dual_bus_buf #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_LEN = 16,
  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1),
  localparam int unsigned PTR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              rd_last_c,
  output logic              last_slot_c,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [MAX_LEN];
  logic [PTR_W-1:0]  rd_ptr;

  // Storage needs no reset: contents are only read back below 'count'.
  always_ff @(posedge clk) begin
    if (wr_en) mem[PTR_W'(count)] <= wr_data;
  end

  // Write count doubles as the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) count  <= count + CNT_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  assign rd_data_c   = mem[rd_ptr];
  assign rd_last_c   = (CNT_W'(rd_ptr) + CNT_W'(1)) == count;
  assign last_slot_c = count == CNT_W'(MAX_LEN - 1);

endmodule

// File: rtl/dual_bus_tx.sv
// dual_bus_tx: dual-channel redundant bus frame transmitter.
// Buffers one frame from a valid/ready word stream, then emits
// SYNC, LEN, payload and XOR checksum identically on channels A and B.
// Optional feature macro: FAULT_INJECT_EN (adds fi_arm; flips bit 0 of
// channel B's first payload word once per arm).
//   clk, rst            - clock, asynchronous active-high reset
//   s_valid/s_ready     - input handshake; s_data word, s_last frame end
//   a_valid/a_data      - channel A output
//   b_valid/b_data      - channel B output
//   tx_sof              - high on the SYNC word cycle
//   busy                - frame in progress (first accept to end of gap)
//   len_err             - one-cycle pulse on truncation at MAX_LEN
//   frame_cnt           - frames sent, wrapping
//   fi_arm              - fault inject request (FAULT_INJECT_EN only)
module dual_bus_tx
  import dual_bus_pkg::*;
#(
  parameter int unsigned        DATA_W     = 8,
  parameter int unsigned        MAX_LEN    = 16,
  parameter int unsigned        GAP_CYCLES = 2,
  parameter logic [DATA_W-1:0]  SYNC_WORD  = DATA_W'(SYNC_WORD_DFLT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              a_valid,
  output logic [DATA_W-1:0] a_data,
  output logic              b_valid,
  output logic [DATA_W-1:0] b_data,
  output logic              tx_sof,
  output logic              busy,
  output logic              len_err,
  output logic [15:0]       frame_cnt
`ifdef FAULT_INJECT_EN
  ,
  input  logic              fi_arm
`endif
);

  localparam int unsigned CNT_W    = $clog2(MAX_LEN + 1);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t state, next_state;

  logic              accept_c;
  logic              buf_wr, buf_rd, buf_clr;
  logic [DATA_W-1:0] rd_data_c;
  logic              rd_last_c, last_slot_c;
  logic [CNT_W-1:0]  count;

  logic [DATA_W-1:0] csum_q, csum_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              s_ready_d, a_valid_d, tx_sof_d, busy_d, len_err_d, cnt_inc;
  logic [DATA_W-1:0] a_data_d, b_data_d;

  assign accept_c = s_valid && s_ready;

  dual_bus_buf #(
    .DATA_W (DATA_W),
    .MAX_LEN(MAX_LEN)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (buf_clr),
    .wr_en      (buf_wr),
    .wr_data    (s_data),
    .rd_en      (buf_rd),
    .rd_data_c  (rd_data_c),
    .rd_last_c  (rd_last_c),
    .last_slot_c(last_slot_c),
    .count      (count)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state and next output values; outputs are registered below.
  always_comb begin
    next_state = state;
    a_valid_d  = 1'b0;
    a_data_d   = '0;
    tx_sof_d   = 1'b0;
    len_err_d  = 1'b0;
    cnt_inc    = 1'b0;
    buf_wr     = 1'b0;
    buf_rd     = 1'b0;
    buf_clr    = 1'b0;
    csum_d     = csum_q;
    gap_d      = gap_q;

    case (state)
      ST_IDLE, ST_LOAD: begin
        if (accept_c) begin
          buf_wr = 1'b1;
          if (s_last) begin
            next_state = ST_SYNC;
          end else if (last_slot_c) begin
            // MAX_LEN-th word without s_last: close and flag truncation.
            next_state = ST_SYNC;
            len_err_d  = 1'b1;
          end else begin
            next_state = ST_LOAD;
          end
        end
      end
      ST_SYNC: begin
        a_valid_d  = 1'b1;
        a_data_d   = SYNC_WORD;
        tx_sof_d   = 1'b1;
        next_state = ST_LEN;
      end
      ST_LEN: begin
        a_valid_d  = 1'b1;
        a_data_d   = DATA_W'(count);
        csum_d     = DATA_W'(count);
        next_state = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        a_valid_d = 1'b1;
        a_data_d  = rd_data_c;
        csum_d    = DATA_W'(csum_update(CSUM_W'(csum_q), CSUM_W'(rd_data_c)));
        buf_rd    = 1'b1;
        if (rd_last_c) next_state = ST_CSUM;
      end
      ST_CSUM: begin
        a_valid_d = 1'b1;
        a_data_d  = csum_q;
        cnt_inc   = 1'b1;
        buf_clr   = 1'b1;
        gap_d     = '0;
        if (GAP_CYCLES == 0) next_state = ST_IDLE;
        else                 next_state = ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP_LAST)) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase

    // Ready/busy are registered from the upcoming state so they line up with it.
    s_ready_d = (next_state == ST_IDLE) || (next_state == ST_LOAD);
    busy_d    = next_state != ST_IDLE;
  end

`ifdef FAULT_INJECT_EN
  logic fi_armed_q;
  logic pl_first_q;
  logic fi_hit_c;

  // pl_first_q is high exactly during the first PAYLOAD cycle (LEN precedes it).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fi_armed_q <= 1'b0;
      pl_first_q <= 1'b0;
    end else begin
      pl_first_q <= state == ST_LEN;
      if (fi_hit_c)
        fi_armed_q <= 1'b0;
      else if (fi_arm && ((state == ST_IDLE) || (state == ST_LOAD)))
        fi_armed_q <= 1'b1;
    end
  end

  assign fi_hit_c = fi_armed_q && pl_first_q && (state == ST_PAYLOAD);
  assign b_data_d = a_data_d ^ {{(DATA_W-1){1'b0}}, fi_hit_c};
`else
  assign b_data_d = a_data_d;
`endif

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready   <= 1'b0;
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      a_data    <= '0;
      b_data    <= '0;
      tx_sof    <= 1'b0;
      busy      <= 1'b0;
      len_err   <= 1'b0;
      frame_cnt <= '0;
      csum_q    <= '0;
      gap_q     <= '0;
    end else begin
      s_ready <= s_ready_d;
      a_valid <= a_valid_d;
      b_valid <= a_valid_d;
      a_data  <= a_data_d;
      b_data  <= b_data_d;
      tx_sof  <= tx_sof_d;
      busy    <= busy_d;
      len_err <= len_err_d;
      csum_q  <= csum_d;
      gap_q   <= gap_d;
      if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
